// File: rtl/div_ctrl_pkg.sv
// Shared constants and types for the multi-cycle DIV/DIVU sequencer.
package div_ctrl_pkg;

    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned CNT_W    = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StSign,
        StDone
    } div_state_e;

    // Magnitude of a 32-bit operand; raw value when the operation is unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_ctrl_if;

    logic        start;
    logic        signed_div;
    logic        flush;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    modport master (
        output start, signed_div, flush, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_div, flush, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step (
    input  logic [32:0] part_rem,
    input  logic [31:0] divisor,
    input  logic        dvd_bit,
    output logic [32:0] next_rem,
    output logic        q_bit
);

    logic [33:0] shifted;
    logic [32:0] diff;

    always_comb begin
        shifted  = {part_rem, dvd_bit};
        diff     = shifted[32:0] - {1'b0, divisor};
        q_bit    = (shifted >= {2'b00, divisor});
        next_rem = q_bit ? diff : shifted[32:0];
    end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: 32 restoring iterations on magnitudes, then a sign fix-up cycle.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    div_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(DIV_ITER - 1);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [32:0]      part_rem;
    logic [31:0]      dvd_sh;   // dividend bits shift out MSB-first, quotient bits shift in
    logic [31:0]      dvs;
    logic             q_neg;
    logic             r_neg;
    logic             dz;

    logic             busy_r;
    logic             done_r;
    logic             dz_r;
    logic [31:0]      quo_r;
    logic [31:0]      rem_r;

    logic [32:0]      step_rem;
    logic             step_q;

    div_step u_step (
        .part_rem (part_rem),
        .divisor  (dvs),
        .dvd_bit  (dvd_sh[31]),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            cnt      <= '0;
            part_rem <= '0;
            dvd_sh   <= '0;
            dvs      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dz       <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dz_r     <= 1'b0;
            quo_r    <= '0;
            rem_r    <= '0;
        end else if (bus.flush) begin
            // Abandon in-flight work; result registers keep the last completed values.
            state  <= StIdle;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        dvd_sh   <= abs32(bus.dividend, bus.signed_div);
                        dvs      <= abs32(bus.divisor, bus.signed_div);
                        q_neg    <= bus.signed_div & (bus.dividend[31] ^ bus.divisor[31]);
                        r_neg    <= bus.signed_div & bus.dividend[31];
                        dz       <= (bus.divisor == 32'd0);
                        part_rem <= '0;
                        cnt      <= '0;
                        busy_r   <= 1'b1;
                        state    <= StCalc;
                    end else begin
                        state <= StIdle;
                    end
                end
                StCalc: begin
                    part_rem <= step_rem;
                    dvd_sh   <= {dvd_sh[30:0], step_q};
                    cnt      <= cnt + 1'b1;
                    if (cnt == LastIter) begin
                        state <= StSign;
                    end
                end
                StSign: begin
                    // With a zero divisor every trial succeeds, so the loop leaves |dividend| in
                    // the remainder and the r_neg fix-up restores the original dividend.
                    quo_r  <= dz ? 32'hFFFF_FFFF : (q_neg ? (~dvd_sh + 32'd1) : dvd_sh);
                    rem_r  <= r_neg ? (~part_rem[31:0] + 32'd1) : part_rem[31:0];
                    dz_r   <= dz;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= StDone;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dz_r;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed scoreboard bench for div_ctrl: latency, results, flush, back-to-back and reset.
module tb_div_ctrl;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   fails = 0;
    res_t sb[$];

    div_ctrl_if bus ();

    div_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: MIPS truncating division with the forced divide-by-zero result.
    function automatic res_t model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        res_t res;
        res.dz = (b == 32'd0);
        if (b == 32'd0) begin
            res.q = 32'hFFFF_FFFF;
            res.r = a;
        end else if (!sd) begin
            res.q = a / b;
            res.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res.q = 32'h8000_0000;
            res.r = 32'd0;
        end else begin
            res.q = 32'($signed(a) / $signed(b));
            res.r = 32'($signed(a) % $signed(b));
        end
        return res;
    endfunction

    // Drives start for one edge; afterwards the bench sits in cycle 1.
    task automatic launch(input logic sd, input logic [31:0] a, input logic [31:0] b,
                          input bit completes);
        bus.signed_div = sd;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.start      = 1'b1;
        if (completes) sb.push_back(model(sd, a, b));
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int   lat = 1;
        int   busy_n = 0;
        bit   seen = 0;
        res_t exp;
        for (int i = 0; i < 45 && !seen; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1;
            end else begin
                if (bus.busy === 1'b1) busy_n++;
                tick();
                lat++;
            end
        end
        chk({tag, " done seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'd34);
        chk({tag, " busy cycles"}, 32'(busy_n), 32'd33);
        chk({tag, " busy in done"}, 32'(bus.busy), 32'd0);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard entry"}, 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            chk({tag, " quotient"}, bus.quotient, exp.q);
            chk({tag, " remainder"}, bus.remainder, exp.r);
            chk({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(exp.dz));
        end
    endtask

    task automatic count_done(input string tag, input int cycles);
        int n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.done === 1'b1) n++;
            tick();
        end
        chk({tag, " stray done"}, 32'(n), 32'd0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.flush      = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        tick();
        tick();
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset quotient", bus.quotient, 32'd0);
        chk("reset remainder", bus.remainder, 32'd0);
        chk("reset dz", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        tick();

        launch(1'b0, 32'd100, 32'd7, 1'b1);
        chk("divu busy cycle1", 32'(bus.busy), 32'd1);
        wait_done("divu 100/7");
        launch(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done("div -7/2");
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("div overflow");
        launch(1'b0, 32'h1234, 32'd0, 1'b1);
        wait_done("divu by zero");
        launch(1'b1, 32'h8000_0000, 32'd0, 1'b1);
        wait_done("div by zero neg");
        launch(1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 1'b1);
        wait_done("divu large");

        // Flush in cycle 10 of 50/5 after a completed 100/7.
        launch(1'b0, 32'd100, 32'd7, 1'b1);
        wait_done("pre-flush 100/7");
        tick();
        launch(1'b0, 32'd50, 32'd5, 1'b0);
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush busy", 32'(bus.busy), 32'd0);
        count_done("flush", 40);
        chk("flush quotient held", bus.quotient, 32'd14);
        chk("flush remainder held", bus.remainder, 32'd2);
        chk("flush dz held", 32'(bus.div_by_zero), 32'd0);
        launch(1'b1, 32'd50, 32'hFFFF_FFFB, 1'b1);
        wait_done("after flush 50/-5");

        // Back-to-back: start held during DONE.
        tick();
        launch(1'b0, 32'd9, 32'd3, 1'b1);
        wait_done("b2b 9/3");
        launch(1'b0, 32'd20, 32'd6, 1'b1);
        wait_done("b2b 20/6");

        // Reset in cycle 5 of another operation.
        tick();
        launch(1'b0, 32'd1000, 32'd3, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("mid rst busy", 32'(bus.busy), 32'd0);
        chk("mid rst done", 32'(bus.done), 32'd0);
        chk("mid rst quotient", bus.quotient, 32'd0);
        chk("mid rst remainder", bus.remainder, 32'd0);
        tick();
        rst = 1'b0;
        count_done("mid rst", 40);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle sequencer for MIPS DIV/DIVU in the execute stage, alongside the single-cycle ALU. It accepts one division request through a start/busy/done handshake and runs a 32-iteration restoring shift-subtract loop. It delivers a registered quotient and remainder for the HI/LO write-back. It asserts a stall request while iterating and abandons work on a pipeline flush.

## Interface
- No parameters; the iteration count `DIV_ITER` = 32 is a shared constant.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request, sampled on the rising edge; accepted only in IDLE or DONE.
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `flush`  in  1  synchronous abort from the exception/branch unit.
- `dividend`  in  32  rs operand; sampled with `start`.
- `divisor`  in  32  rt operand; sampled with `start`.
- `busy`  out  1  high while the operation is in flight; drives the pipeline stall.
- `done`  out  1  one-cycle pulse; `quotient` and `remainder` are valid in this cycle.
- `quotient`  out  32  LO value; held until the next completed operation.
- `remainder`  out  32  HI value; held until the next completed operation.
- `div_by_zero`  out  1  valid with `done`; high when the sampled divisor was 0.

## Operation
- States: IDLE, CALC, SIGN, DONE.
  - IDLE→CALC on `start`.
  - CALC→SIGN when the iteration counter reaches 31.
  - SIGN→DONE unconditionally.
  - DONE→IDLE, or DONE→CALC if `start` is high.
- Accepting a request:
  - Latch |dividend| and |divisor|; use raw values when `signed_div`=0.
  - Latch the sign flags `q_neg` = dividend[31]^divisor[31] and `r_neg` = dividend[31]; both are forced 0 when unsigned.
  - Clear the 33-bit partial remainder and the 5-bit counter.
- CALC step, one per cycle, MSB first:
  - Shift {partial remainder, dividend register} left by 1.
  - Trial-subtract the divisor (33-bit).
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
- SIGN:
  - Negate the quotient if `q_neg`; negate the remainder if `r_neg`.
  - Write both to the output registers.
- Divide by zero:
  - Same latency as a normal operation.
  - Forced result: `quotient` = 32'hFFFF_FFFF, `remainder` = original dividend (signed and unsigned), `div_by_zero` = 1.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF → `quotient` 0x8000_0000, `remainder` 0; no flag.
- `flush` in any state:
  - Next state is IDLE; no `done` for the aborted operation.
  - `quotient`, `remainder` and `div_by_zero` keep their previous values.
  - `flush` has priority over a simultaneous `start`.
- `start` in CALC or SIGN is ignored; the requester holds it only while `busy` is low.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `quotient` 0, `remainder` 0, `div_by_zero` 0, counter 0.
- Request timeline (start sampled high at the end of cycle 0):
  - Cycles 1–32: CALC.
  - Cycle 33: SIGN.
  - Cycle 34: DONE, with `done` = 1.
- Latency is 34 cycles from start to done, independent of operand values.
- `busy` is registered: high in cycles 1–33, low in DONE and IDLE. The issuing stage therefore stalls from cycle 1; in cycle 0 it must stall on its own decode of a DIV instruction.
- Throughput: one division per 34 cycles back-to-back, by accepting `start` in DONE.
- `rst` asserted mid-operation: immediate return to the reset values, with no `done`.

## Structure
- Add the state encodings and `DIV_ITER` as `define`s in `global_define.vh`, next to the existing ALU op codes.
- One combinational sub-module, `div_step`: 33-bit partial remainder, 32-bit divisor and incoming dividend bit in; next partial remainder and quotient bit out.
- The FSM, counter, operand registers and sign fix-up stay in `div_ctrl`.

## Test plan
- DIVU 100 / 7:
  - `done` exactly 34 cycles after `start`; `quotient` 14, `remainder` 2.
  - `busy` high for exactly 33 cycles.
- DIV −7 / 2 (0xFFFF_FFF9 / 2): `quotient` 0xFFFF_FFFD (−3), `remainder` 0xFFFF_FFFF (−1).
- DIV 0x8000_0000 / 0xFFFF_FFFF: `quotient` 0x8000_0000, `remainder` 0, `div_by_zero` 0.
- DIVU 0x1234 / 0: `done` at 34 cycles; `quotient` 0xFFFF_FFFF, `remainder` 0x1234, `div_by_zero` 1.
- Flush in cycle 10 of a DIVU 50/5 that follows a completed 100/7:
  - State IDLE next cycle; no `done` pulse.
  - Outputs still read 14 and 2.
  - A new `start` is then accepted normally.
- Back-to-back: `start` held high during DONE of 9/3, with next operands 20/6:
  - First `done` gives 3/0; the second `done` follows 34 cycles later and gives 3/2.
  - `rst` pulsed in cycle 5 of another operation returns all outputs to 0.
